commit_unit: RTL and testbench

COMMIT_UNIT -- requirements
Module: commit_unit

---
 rtl/commit_unit.sv | 162 ++++++++++++++++
 tb/tb_commit_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
// In-order commit stage: retires the reorder-buffer head into the register file or data memory.
// Optional exception flush path is enabled by defining COMMIT_EXCEPTION_EN.
module commit_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rob_valid,
    input  logic [31:0]      rob_val,
    input  logic [4:0]       rob_rd,
    input  logic             rob_store,
    input  logic [31:0]      rob_addr,
    input  logic             rob_ex,
    input  logic [31:0]      rob_pc,
    output logic             next_head,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [31:0]      rf_val,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    output logic             ex_flush,
    output logic [31:0]      ex_epc,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        RETIRE
`ifdef COMMIT_EXCEPTION_EN
        , EXC
`endif
    } state_t;

    state_t state, state_nxt;

    logic             next_head_d;
    logic             rf_we_d;
    logic [4:0]       rf_rd_d;
    logic [31:0]      rf_val_d;
    logic             mem_req_d;
    logic [31:0]      mem_addr_d;
    logic [31:0]      mem_wdata_d;
    logic [CNT_W-1:0] retired_d;

`ifdef COMMIT_EXCEPTION_EN
    logic        ex_flush_d;
    logic [31:0] ex_epc_d;
    logic        take_ex;
    assign take_ex = rob_ex;
`else
    logic take_ex;
    logic unused_ex;
    assign take_ex   = 1'b0;
    assign unused_ex = ^{rob_ex, rob_pc};
    assign ex_flush  = 1'b0;
    assign ex_epc    = 32'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            next_head <= 1'b0;
            rf_we     <= 1'b0;
            rf_rd     <= 5'd0;
            rf_val    <= 32'd0;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            retired   <= '0;
`ifdef COMMIT_EXCEPTION_EN
            ex_flush  <= 1'b0;
            ex_epc    <= 32'd0;
`endif
        end else begin
            state     <= state_nxt;
            next_head <= next_head_d;
            rf_we     <= rf_we_d;
            rf_rd     <= rf_rd_d;
            rf_val    <= rf_val_d;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            retired   <= retired_d;
`ifdef COMMIT_EXCEPTION_EN
            ex_flush  <= ex_flush_d;
            ex_epc    <= ex_epc_d;
`endif
        end
    end

    // The ROB head is only looked at from IDLE; RETIRE gives the head one edge to advance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rob_valid) begin
                    if (take_ex) begin
`ifdef COMMIT_EXCEPTION_EN
                        state_nxt = EXC;
`endif
                    end else if (rob_store) begin
                        state_nxt = STORE;
                    end else begin
                        state_nxt = RETIRE;
                    end
                end
            end
            STORE:   if (mem_ack) state_nxt = RETIRE;
            RETIRE:  state_nxt = IDLE;
`ifdef COMMIT_EXCEPTION_EN
            EXC:     state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        next_head_d = 1'b0;
        rf_we_d     = 1'b0;
        rf_rd_d     = rf_rd;
        rf_val_d    = rf_val;
        mem_req_d   = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
`ifdef COMMIT_EXCEPTION_EN
        ex_flush_d  = 1'b0;
        ex_epc_d    = ex_epc;
`endif
        case (state)
            IDLE: begin
                if (rob_valid) begin
                    if (take_ex) begin
                        next_head_d = 1'b1;
`ifdef COMMIT_EXCEPTION_EN
                        ex_flush_d  = 1'b1;
                        ex_epc_d    = rob_pc;
`endif
                    end else if (rob_store) begin
                        mem_req_d   = 1'b1;
                        mem_addr_d  = rob_addr;
                        mem_wdata_d = rob_val;
                    end else begin
                        next_head_d = 1'b1;
                        rf_we_d     = (rob_rd != 5'd0);
                        rf_rd_d     = rob_rd;
                        rf_val_d    = rob_val;
                    end
                end
            end
            STORE: begin
                mem_req_d   = !mem_ack;
                next_head_d = mem_ack;
            end
            default: ;
        endcase
        retired_d = retired + CNT_W'(next_head_d);
    end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: a queue of expected retirements is checked every cycle.
module tb_commit_unit;

    localparam int CNT_W   = 4;
    localparam int K_ALU   = 0;
    localparam int K_STORE = 1;
    localparam int K_EXC   = 2;

    logic             clk;
    logic             rst_n;
    logic             rob_valid;
    logic [31:0]      rob_val;
    logic [4:0]       rob_rd;
    logic             rob_store;
    logic [31:0]      rob_addr;
    logic             rob_ex;
    logic [31:0]      rob_pc;
    logic             next_head;
    logic             rf_we;
    logic [4:0]       rf_rd;
    logic [31:0]      rf_val;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic             ex_flush;
    logic [31:0]      ex_epc;
    logic [CNT_W-1:0] retired;

    commit_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rob_valid(rob_valid), .rob_val(rob_val), .rob_rd(rob_rd),
        .rob_store(rob_store), .rob_addr(rob_addr), .rob_ex(rob_ex), .rob_pc(rob_pc),
        .next_head(next_head), .rf_we(rf_we), .rf_rd(rf_rd), .rf_val(rf_val),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .ex_flush(ex_flush), .ex_epc(ex_epc), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] addr;
        logic [31:0] pc;
    } entry_t;

    entry_t exp_q[$];
    entry_t cur;
    int     model_cnt = 0;
    int     vectors = 0;
    int     miscompares = 0;
    logic   prev_nh = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle out of reset, outputs must agree with the head of the expected-retirement queue.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("nh_single_cycle", {31'd0, prev_nh & next_head}, 32'd0);
            if (next_head) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    model_cnt++;
                    if (cur.kind == K_ALU) begin
                        checkOutput("alu_rf_we", {31'd0, rf_we}, {31'd0, cur.rd != 5'd0});
                        checkOutput("alu_rf_rd", {27'd0, rf_rd}, {27'd0, cur.rd});
                        checkOutput("alu_rf_val", rf_val, cur.val);
                        checkOutput("alu_ex_flush", {31'd0, ex_flush}, 32'd0);
                    end else if (cur.kind == K_STORE) begin
                        checkOutput("st_rf_we", {31'd0, rf_we}, 32'd0);
                        checkOutput("st_mem_req", {31'd0, mem_req}, 32'd0);
                        checkOutput("st_ex_flush", {31'd0, ex_flush}, 32'd0);
                    end else begin
                        checkOutput("ex_flush", {31'd0, ex_flush}, 32'd1);
                        checkOutput("ex_epc", ex_epc, cur.pc);
                        checkOutput("ex_rf_we", {31'd0, rf_we}, 32'd0);
                        checkOutput("ex_mem_req", {31'd0, mem_req}, 32'd0);
                    end
                end
            end else begin
                checkOutput("idle_rf_we", {31'd0, rf_we}, 32'd0);
                checkOutput("idle_ex_flush", {31'd0, ex_flush}, 32'd0);
                if (mem_req) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != K_STORE) begin
                        checkOutput("unexpected_mem_req", 32'd1, 32'd0);
                    end else begin
                        checkOutput("mem_addr", mem_addr, exp_q[0].addr);
                        checkOutput("mem_wdata", mem_wdata, exp_q[0].val);
                    end
                end
            end
            checkOutput("retired", 32'(retired), 32'(model_cnt % (1 << CNT_W)));
            prev_nh = next_head;
        end else begin
            prev_nh = 1'b0;
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_next_head"}, {31'd0, next_head}, 32'd0);
        checkOutput({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        checkOutput({tag, "_rf_rd"}, {27'd0, rf_rd}, 32'd0);
        checkOutput({tag, "_rf_val"}, rf_val, 32'd0);
        checkOutput({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_ex_flush"}, {31'd0, ex_flush}, 32'd0);
        checkOutput({tag, "_ex_epc"}, ex_epc, 32'd0);
        checkOutput({tag, "_retired"}, 32'(retired), 32'd0);
    endtask

    task automatic resetDut();
        rob_valid = 1'b0;
        mem_ack   = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkResetState("rst");
        repeat (2) @(negedge clk);
        exp_q.delete();
        model_cnt = 0;
        rst_n = 1'b1;
    endtask

    // Presents one head entry and waits (bounded) for its retirement pulse.
    task automatic applyStimulus(input int kind, input logic st, input logic ex,
                                 input logic [4:0] rd, input logic [31:0] val,
                                 input logic [31:0] addr, input logic [31:0] pc,
                                 input int ack_wait, output int cycles, output int req_cycles);
        entry_t e;
        e.kind = kind; e.rd = rd; e.val = val; e.addr = addr; e.pc = pc;
        exp_q.push_back(e);
        rob_valid = 1'b1; rob_store = st; rob_ex = ex;
        rob_rd = rd; rob_val = val; rob_addr = addr; rob_pc = pc;
        cycles = 0;
        req_cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (mem_req) req_cycles++;
            if (next_head) break;
            if (cycles >= 60) begin
                checkOutput("retire_timeout", 32'(cycles), 32'd0);
                break;
            end
            if (mem_req) begin
                if (req_cycles == 1) begin
                    rob_addr = ~addr; rob_val = ~val; rob_rd = ~rd;
                end
                if (req_cycles >= ack_wait) mem_ack = 1'b1;
            end
        end
        mem_ack = 1'b0;
        rob_store = 1'b0;
        rob_ex = 1'b0;
    endtask

    int cyc, req;

    initial begin
        rst_n = 1'b1; rob_valid = 1'b0; rob_val = '0; rob_rd = '0; rob_store = 1'b0;
        rob_addr = '0; rob_ex = 1'b0; rob_pc = '0; mem_ack = 1'b0;
        #1;
        resetDut();

        applyStimulus(K_ALU, 1'b0, 1'b0, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 0, cyc, req);
        checkOutput("alu_latency", 32'(cyc), 32'd1);
        checkOutput("alu_lit_rf_we", {31'd0, rf_we}, 32'd1);
        checkOutput("alu_lit_rf_rd", {27'd0, rf_rd}, 32'd5);
        checkOutput("alu_lit_rf_val", rf_val, 32'h1234_5678);
        checkOutput("alu_lit_retired", 32'(retired), 32'd1);
        rob_valid = 1'b0;
        @(negedge clk);
        checkOutput("alu_pulse_end", {31'd0, next_head}, 32'd0);
        @(negedge clk);

        applyStimulus(K_ALU, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, cyc, req);
        checkOutput("rd0_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("rd0_retired", 32'(retired), 32'd2);
        rob_valid = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulus(K_STORE, 1'b1, 1'b0, 5'd7, 32'hCAFE_BABE, 32'h100, 32'h0, 3, cyc, req);
        checkOutput("st_req_cycles", 32'(req), 32'd3);
        checkOutput("st_latency", 32'(cyc), 32'd4);
        checkOutput("st_lit_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("st_lit_retired", 32'(retired), 32'd3);
        rob_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Store that never gets an ack, cut short by reset.
        cur.kind = K_STORE; cur.rd = 5'd0; cur.val = 32'h5555_AAAA; cur.addr = 32'h300; cur.pc = 32'h0;
        exp_q.push_back(cur);
        rob_valid = 1'b1; rob_store = 1'b1; rob_val = 32'h5555_AAAA; rob_addr = 32'h300;
        req = 0;
        for (int i = 0; i < 10 && req < 2; i++) begin
            @(negedge clk);
            if (mem_req) req++;
        end
        checkOutput("rst_store_req_seen", 32'(req), 32'd2);
        #2;
        rob_store = 1'b0;
        resetDut();
        checkOutput("rst_store_retired", 32'(retired), 32'd0);
        repeat (2) @(negedge clk);

        mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("stray_ack_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("stray_ack_next_head", {31'd0, next_head}, 32'd0);

        applyStimulus(K_ALU, 1'b0, 1'b0, 5'd31, 32'hA5A5_5A5A, 32'h0, 32'h0, 0, cyc, req);
        checkOutput("post_rst_retired", 32'(retired), 32'd1);
        rob_valid = 1'b0;
        repeat (2) @(negedge clk);

`ifdef COMMIT_EXCEPTION_EN
        applyStimulus(K_EXC, 1'b1, 1'b1, 5'd3, 32'h0BAD_F00D, 32'h200, 32'h40, 1, cyc, req);
        checkOutput("exc_lit_flush", {31'd0, ex_flush}, 32'd1);
        checkOutput("exc_lit_epc", ex_epc, 32'h40);
        checkOutput("exc_no_mem_req", 32'(req), 32'd0);
        rob_valid = 1'b0;
        @(negedge clk);
        checkOutput("exc_flush_end", {31'd0, ex_flush}, 32'd0);
`else
        applyStimulus(K_STORE, 1'b1, 1'b1, 5'd3, 32'h0BAD_F00D, 32'h200, 32'h40, 1, cyc, req);
        checkOutput("noexc_store_req", 32'(req), 32'd1);
        checkOutput("noexc_flush", {31'd0, ex_flush}, 32'd0);
        rob_valid = 1'b0;
        @(negedge clk);
`endif
        checkOutput("exc_entry_retired", 32'(retired), 32'd2);
        @(negedge clk);

        resetDut();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(K_ALU, 1'b0, 1'b0, 5'(i), 32'h1000_0000 + 32'(i), 32'h0, 32'h0, 0, cyc, req);
            if (i > 0) checkOutput("b2b_interval", 32'(cyc), 32'd2);
        end
        rob_valid = 1'b0;
        checkOutput("wrap_retired", 32'(retired), 32'd1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
